ex_muldiv_seq: RTL

Multi-cycle sequencer for the RV64M multiply/divide operations that the single-cycle EX ALU does not implement. It sits beside the EX ALU and captures operands when EX issues an M-extension op. It runs an iterative shift-add multiply or restoring divide one bit per cycle, holds the pipeline with `stall` while busy, and presents a registered 64-bit result with a one-cycle `done` strobe.

---
 rtl/ex_muldiv_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: multi-cycle RV64M multiply/divide sequencer beside the EX ALU.
// Captures operands on an accepted start, runs shift-add multiply or restoring
// divide one bit per cycle, and returns a registered result with a done strobe.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   start    - issue request (sampled only in IDLE)
//   op       - funct3 of the M-extension op
//   word     - *W variant: 32-bit op, result sign-extended from bit 31
//   flush    - pipeline kill, aborts any operation (priority over start)
//   oprand1  - rs1 value (multiplicand / dividend)
//   oprand2  - rs2 value (multiplier / divisor)
//   result   - registered result, held until the next accepted operation
//   done     - one-cycle strobe, result valid
//   stall    - pipeline hold to EX
//
// state | meaning
// IDLE  | waiting for start; special divide cases resolved here
// CALC  | one multiply/divide bit per cycle, N = 64 or 32 iterations
// FIXUP | sign correction and result selection
// DONE  | done strobe for one cycle

module ex_muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic            flush,
    input  logic [XLEN-1:0] oprand1,
    input  logic [XLEN-1:0] oprand2,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            stall
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              word_q;
    logic              res_neg;
    logic              rem_neg;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc;     // multiply: product; divide: {remainder, dividend/quotient}
    logic [2*XLEN-1:0] mcand;   // multiplicand, shifted left each iteration
    logic [XLEN-1:0]   mplier;  // multiplier (shifted right) or divisor

    // Issue-time operand preparation
    logic              is_div, sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]   ext1, ext2, dvd_sx, mag1, mag2;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_val;

    always_comb begin
        is_div   = op[2];
        sgn1     = is_div ? ~op[0] : (op[1:0] != 2'b11);
        sgn2     = is_div ? ~op[0] : ~op[1];
        ext1     = word ? {{32{sgn1 & oprand1[31]}}, oprand1[31:0]} : oprand1;
        ext2     = word ? {{32{sgn2 & oprand2[31]}}, oprand2[31:0]} : oprand2;
        dvd_sx   = word ? {{32{oprand1[31]}}, oprand1[31:0]} : oprand1;
        neg1     = sgn1 & ext1[XLEN-1];
        neg2     = sgn2 & ext2[XLEN-1];
        mag1     = neg1 ? (XLEN'(0) - ext1) : ext1;
        mag2     = neg2 ? (XLEN'(0) - ext2) : ext2;
        div_zero = is_div & (ext2 == '0);
        div_ovf  = is_div & ~op[0] & (ext2 == '1) &
                   (word ? (ext1 == {{33{1'b1}}, 31'b0}) : (ext1 == {1'b1, 63'b0}));
        // Divide by zero: quotient all ones, remainder = dividend.
        // Overflow: quotient = dividend, remainder = 0.
        if (div_zero)
            special_val = op[1] ? dvd_sx : '1;
        else
            special_val = op[1] ? '0 : ext1;
    end

    // One iteration of multiply or restoring divide
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh, diff;
    logic              q_bit;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_next = acc + (mplier[0] ? mcand : '0);
        rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = rem_sh - {1'b0, mplier};
        q_bit    = ~diff[XLEN];
        div_next = {(q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], q_bit};
    end

    // Final sign fix and selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, sel, fin;

    always_comb begin
        prod = res_neg ? ((2*XLEN)'(0) - acc) : acc;
        quo  = res_neg ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem  = rem_neg ? (XLEN'(0) - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        if (op_q[2])
            sel = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00 || word_q)
            sel = prod[XLEN-1:0];
        else
            sel = prod[2*XLEN-1:XLEN];
        fin = word_q ? {{32{sel[31]}}, sel[31:0]} : sel;
    end

    assign stall = ((state == IDLE) & start & ~flush) | (state == CALC) | (state == FIXUP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            word_q  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        word_q  <= word;
                        res_neg <= neg1 ^ neg2;
                        rem_neg <= neg1;
                        cnt     <= '0;
                        mplier  <= mag2;
                        mcand   <= {{XLEN{1'b0}}, mag1};
                        // Word divide left-aligns the 32-bit dividend so the
                        // shift loop consumes its MSB first.
                        acc     <= is_div ? {{XLEN{1'b0}}, (word ? {mag1[31:0], 32'b0} : mag1)} : '0;
                        if (div_zero || div_ovf) begin
                            result <= special_val;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        acc <= div_next;
                    end else begin
                        acc    <= mul_next;
                        mcand  <= {mcand[2*XLEN-2:0], 1'b0};
                        mplier <= {1'b0, mplier[XLEN-1:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == (word_q ? 6'd31 : 6'd63))
                        state <= FIXUP;
                end
                FIXUP: begin
                    result <= fin;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
